uc_fsm: RTL and testbench
=========================

UC_FSM -- requirements
Module: uc_fsm

Interface
REQ-001 The module SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum wait cycles per memory handshake (legal range 1..15).
REQ-002 The module SHALL have exactly one clock and one reset, with reset synchronous and active-high.
REQ-003 The ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- start  in  1  leave IDLE
- halt_req  in  1  stop at next retirement
- opcode  in  4  instruction opcode field, valid while imem_ready=1
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- imem_req  out  1  fetch request
- ir_load  out  1  capture instruction
- pc_en  out  1  advance PC
- alu_op  out  2  ALU operation select
- mem_read  out  1  data read strobe
- mem_write  out  1  data write strobe
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source select (1 = memory)
- illegal  out  1  one-cycle illegal-opcode pulse
- err  out  1  sticky handshake-timeout error
- state  out  3  current FSM state
- retired  out  16  retired-instruction count

Function
REQ-004 The FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6, registered and driven on state.
REQ-005 Opcodes SHALL be ADD=0000, SUB=0001, LOAD=0010, STORE=0011; all others are illegal.
REQ-006 IDLE SHALL drive all strobes 0 and move to FETCH on the cycle after start=1.
REQ-007 FETCH SHALL assert imem_req; in the cycle imem_ready=1 it SHALL assert ir_load and pc_en, latch opcode internally, and move to DECODE.
REQ-008 DECODE SHALL last one cycle: legal opcode -> EXEC; illegal -> pulse illegal=1 this cycle, no retirement, then FETCH.
REQ-009 EXEC SHALL last one cycle with alu_op ADD=00, SUB=01, LOAD/STORE=10; ADD/SUB -> WB; LOAD/STORE -> MEM.
REQ-010 MEM SHALL hold alu_op=10 and assert mem_read (LOAD) or mem_write (STORE) continuously until the cycle dmem_ready=1; on that cycle LOAD -> WB, STORE retires and goes to FETCH.
REQ-011 WB SHALL last one cycle with reg_write=1, mem_to_reg=1 for LOAD and 0 otherwise, and alu_op held at the EXEC value; it retires the instruction and then goes to FETCH.
REQ-012 Retirement (WB exit, or STORE MEM exit) SHALL increment retired by 1 modulo 2^16; 0xFFFF wraps to 0x0000.
REQ-013 If halt_req=1 in the retirement cycle, the next state SHALL be IDLE instead of FETCH; halt_req at any other time SHALL be ignored.
REQ-014 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle in those states with the relevant ready=0.
REQ-015 If ready=0 while the counter equals MEM_TIMEOUT-1, the next state SHALL be ERR; ready=1 in that same cycle SHALL complete normally.
REQ-016 ERR SHALL drive err=1, all strobes and reg_write 0, ignore start and halt_req, and remain until rst.
REQ-017 alu_op SHALL be 00 and mem_to_reg SHALL be 0 in IDLE, FETCH, DECODE and ERR; no output is ever X.
REQ-018 Zero-wait latency SHALL be ADD/SUB 4 cycles, LOAD 5, STORE 4, from FETCH entry to the next FETCH entry.
REQ-019 The ready inputs SHALL be ignored outside their own states (imem_ready outside FETCH, dmem_ready outside MEM).

Reset
REQ-020 rst=1 at a clock edge SHALL force state=IDLE, retired=0, wait counter=0, err=0, latched opcode=0, and all strobes 0 on the following cycle, from any state including MEM mid-handshake.
REQ-021 rst SHALL take priority over start, ready and halt_req in the same cycle.

Verification
REQ-022 The bench SHALL cover:
- start, ADD with imem_ready and dmem_ready tied 1 -> states 1,2,3,5; reg_write=1 one cycle; alu_op=00 in EXEC; retired 0->1.
- LOAD with dmem_ready delayed 3 cycles -> mem_read high for exactly 4 MEM cycles; WB with mem_to_reg=1; total 8 cycles.
- opcode=0111 -> illegal pulses once in DECODE; back to FETCH; retired unchanged.
- MEM_TIMEOUT=15, STORE with dmem_ready never asserted -> mem_write high 15 cycles, then state=6, err=1 held; rst returns state=0 and err=0.
- halt_req=1 during SUB WB -> state=0 next cycle; retired incremented; no imem_req.
- retired preloaded to 0xFFFF by 65535 retirements, one more ADD -> retired=0x0000.

Source files
------------

// File: rtl/uc_fsm.sv
`default_nettype none
// ============================================================================
// uc_fsm : multi-cycle fetch/decode/execute controller with handshake timeout
// Rev 1.0
// ============================================================================
module uc_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic [3:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_en,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;
  logic        op_legal;
  logic        op_is_mem;
  logic [1:0]  exec_alu;

  assign op_legal  = (op_q[3:2] == 2'b00);
  assign op_is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign exec_alu  = (op_q == OP_ADD) ? 2'b00 :
                     (op_q == OP_SUB) ? 2'b01 : 2'b10;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    retired_d  = retired_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          op_d    = opcode;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op  = exec_alu;
        state_d = op_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_op    = 2'b10;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_LOAD) state_d = S_WB;
          else                 retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        alu_op     = exec_alu;
        retire     = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Halt is only honoured at the instant an instruction retires.
    if (retire) begin
      retired_d = retired_q + 16'd1;
      state_d   = halt_req ? S_IDLE : S_FETCH;
    end

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_d = 4'd0;
    else if (((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready))
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      wait_q    <= 4'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign err     = (state_q == S_ERR);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_uc_fsm.sv
`default_nettype none
// ============================================================================
// tb_uc_fsm : directed self-checking bench for uc_fsm
// Rev 1.0
// ============================================================================
module tb_uc_fsm;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, imem_ready, dmem_ready;
  logic [3:0]  opcode;
  logic        imem_req, ir_load, pc_en, mem_read, mem_write;
  logic        reg_write, mem_to_reg, illegal, err;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, n_rd, n_wr, n_wb, n_ill, n_m2r;

  always #5 clk = ~clk;

  uc_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .err(err),
    .state(state), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until the FSM is back in FETCH, IDLE or ERR.
  task automatic run_instr(input logic [3:0] op, input int dly, input logic hlt,
                           output int c, output int rd, output int wr,
                           output int wb, output int ill, output int m2r);
    int memc;
    c = 0; rd = 0; wr = 0; wb = 0; ill = 0; m2r = 0; memc = 0;
    opcode = op;
    for (int i = 0; i < 40; i++) begin
      dmem_ready = (state == 3'd4) && (memc >= dly);
      halt_req   = hlt && (state == 3'd5);
      #1;
      if (mem_read)   rd++;
      if (mem_write)  wr++;
      if (reg_write)  wb++;
      if (illegal)    ill++;
      if (mem_to_reg) m2r++;
      if (state == 3'd4) memc++;
      tick();
      c++;
      if (state inside {3'd0, 3'd1, 3'd6}) break;
    end
    halt_req   = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; opcode = 4'd0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_state",   32'(state),    32'd0);
    check("reset_retired", 32'(retired),  32'd0);
    check("reset_err",     32'(err),      32'd0);
    check("reset_imemreq", 32'(imem_req), 32'd0);

    // ADD with both ready lines tied high
    opcode = 4'b0000; imem_ready = 1'b1; dmem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    check("add_fetch_state", 32'(state),   32'd1);
    check("add_fetch_irld",  32'(ir_load), 32'd1);
    check("add_fetch_pcen",  32'(pc_en),   32'd1);
    tick(); #1;
    check("add_decode_state", 32'(state), 32'd2);
    tick(); #1;
    check("add_exec_state", 32'(state),  32'd3);
    check("add_exec_alu",   32'(alu_op), 32'd0);
    tick(); #1;
    check("add_wb_state", 32'(state),      32'd5);
    check("add_wb_rw",    32'(reg_write),  32'd1);
    check("add_wb_m2r",   32'(mem_to_reg), 32'd0);
    tick(); #1;
    check("add_next_state", 32'(state),     32'd1);
    check("add_next_rw",    32'(reg_write), 32'd0);
    check("add_retired",    32'(retired),   32'd1);

    // LOAD with dmem_ready delayed 3 cycles
    run_instr(4'b0010, 3, 1'b0, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("load_cycles",  32'(cyc),     32'd8);
    check("load_rd_cyc",  32'(n_rd),    32'd4);
    check("load_wb_cyc",  32'(n_wb),    32'd1);
    check("load_m2r_cyc", 32'(n_m2r),   32'd1);
    check("load_retired", 32'(retired), 32'd2);

    // illegal opcode
    run_instr(4'b0111, 0, 1'b0, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("ill_pulses",  32'(n_ill),   32'd1);
    check("ill_cycles",  32'(cyc),     32'd2);
    check("ill_state",   32'(state),   32'd1);
    check("ill_no_wb",   32'(n_wb),    32'd0);
    check("ill_retired", 32'(retired), 32'd2);

    // SUB with halt during WB
    run_instr(4'b0001, 0, 1'b1, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("halt_cycles",  32'(cyc),      32'd4);
    check("halt_state",   32'(state),    32'd0);
    check("halt_retired", 32'(retired),  32'd3);
    check("halt_imemreq", 32'(imem_req), 32'd0);
    tick(); #1;
    check("halt_stays_idle", 32'(state), 32'd0);

    // zero-wait STORE
    start = 1'b1; tick(); start = 1'b0;
    run_instr(4'b0011, 0, 1'b0, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("store_cycles",  32'(cyc),     32'd4);
    check("store_wr_cyc",  32'(n_wr),    32'd1);
    check("store_no_wb",   32'(n_wb),    32'd0);
    check("store_retired", 32'(retired), 32'd4);

    // STORE with dmem_ready never asserted
    run_instr(4'b0011, 99, 1'b0, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("tmo_wr_cyc",  32'(n_wr),    32'd15);
    check("tmo_state",   32'(state),   32'd6);
    check("tmo_err",     32'(err),     32'd1);
    check("tmo_retired", 32'(retired), 32'd4);
    start = 1'b1; halt_req = 1'b1;
    repeat (3) tick();
    #1;
    check("err_held_state", 32'(state),     32'd6);
    check("err_held_err",   32'(err),       32'd1);
    check("err_no_wr",      32'(mem_write), 32'd0);
    check("err_no_imem",    32'(imem_req),  32'd0);
    rst = 1'b1; tick(); rst = 1'b0; start = 1'b0; halt_req = 1'b0; #1;
    check("rst_state",   32'(state),   32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // 65535 back-to-back ADDs, then one more to wrap the counter
    opcode = 4'b0000; start = 1'b1; tick(); start = 1'b0;
    repeat (4 * 65535) @(posedge clk);
    #1;
    check("wrap_pre_retired", 32'(retired), 32'hFFFF);
    check("wrap_pre_state",   32'(state),   32'd1);
    #1;
    run_instr(4'b0000, 0, 1'b0, cyc, n_rd, n_wr, n_wb, n_ill, n_m2r);
    check("wrap_retired", 32'(retired), 32'h0000);
    check("wrap_cycles",  32'(cyc),     32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
